// File: rtl/ysyx_25040129_lsu_rd_master.sv
// AXI4-Lite single-beat load initiator: align/extend byte, half, word; optional abort via YSYX_25040129_RD_TIMEOUT_EN.
// Latency 3 cycles best case (1 when misaligned); AR/R wait indefinitely on the slave, resp has no backpressure.
module ysyx_25040129_lsu_rd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_req_misaligned;
    logic        w_tmo_hit;
    logic        w_resp_set;
    logic        w_resp_err_nxt;
    logic [31:0] w_resp_data_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign req_ready  = !rst && (r_state == S_IDLE);
    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign araddr     = r_addr;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    // Size 11 behaves as a word, so any set bit 1 demands word alignment.
    assign w_req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                              (req_size[1] && (req_addr[1:0] != 2'b00));

`ifdef YSYX_25040129_RD_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_ADDR) || (r_state == S_DATA)) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo_hit = ((r_state == S_ADDR) || (r_state == S_DATA)) &&
                       (r_tmo_cnt == 16'(TIMEOUT_CYCLES));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_tmo_hit        = 1'b0;
`endif

    always_comb begin
        w_byte = rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = r_addr[1] ? rdata[31:16] : rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An R handshake in the expiry cycle is checked first so it completes normally.
    always_comb begin
        w_state_nxt     = r_state;
        w_resp_set      = 1'b0;
        w_resp_err_nxt  = 1'b0;
        w_resp_data_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_misaligned) begin
                        w_state_nxt    = S_RESP;
                        w_resp_set     = 1'b1;
                        w_resp_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (w_tmo_hit) begin
                    w_state_nxt    = S_RESP;
                    w_resp_set     = 1'b1;
                    w_resp_err_nxt = 1'b1;
                end else if (arready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (rvalid) begin
                    w_state_nxt     = S_RESP;
                    w_resp_set      = 1'b1;
                    w_resp_err_nxt  = (rresp != 2'b00);
                    w_resp_data_nxt = (rresp != 2'b00) ? 32'h0 : w_load_data;
                end else if (w_tmo_hit) begin
                    w_state_nxt    = S_RESP;
                    w_resp_set     = 1'b1;
                    w_resp_err_nxt = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
            end
            r_arvalid    <= (w_state_nxt == S_ADDR);
            r_rready     <= (w_state_nxt == S_DATA);
            r_resp_valid <= (w_state_nxt == S_RESP);
            if (w_resp_set) begin
                r_resp_err  <= w_resp_err_nxt;
                r_resp_data <= w_resp_data_nxt;
            end
        end
    end

endmodule
